// File: rtl/pipelined_select_adder_pkg.sv
// Shared types and helpers for the pipelined carry-select adder.
//   op_e : operation select carried on the 'sub' input
//   nblk : number of carry-select blocks for a given width/block size
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned nblk(input int unsigned width,
                                       input int unsigned block);
    return (block == 0) ? 0 : width / block;
  endfunction

endpackage

// File: rtl/pipelined_select_adder_if.sv
// Operand/result bus of pipelined_select_adder.
//   in_valid/in_ready   : operand beat handshake (A, B, cin, sub)
//   out_valid/out_ready : result beat handshake (S, cout, overflow)
//   master : operand producer / result consumer side
//   slave  : adder side
interface pipelined_select_adder_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, A, B, cin, sub, out_ready,
    input  in_ready, out_valid, S, cout, overflow
  );

  modport slave (
    input  in_valid, A, B, cin, sub, out_ready,
    output in_ready, out_valid, S, cout, overflow
  );

endinterface

// File: rtl/pipelined_select_adder_select_block.sv
// One carry-select block: precomputes the block sum and carry-out for
// both possible carry-ins so the carry chain only has to pick one.
//   a, b         : block operands
//   sum0, carry0 : result assuming carry-in 0
//   sum1, carry1 : result assuming carry-in 1
module select_block #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] sum0,
  output logic [BLOCK-1:0] sum1,
  output logic             carry0,
  output logic             carry1
);

  assign {carry0, sum0} = {1'b0, a} + {1'b0, b};
  assign {carry1, sum1} = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

endmodule

// File: rtl/pipelined_select_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready
// handshakes on both sides.
//   Clk   : clock, rising edge
//   Reset : asynchronous active-high reset, discards in-flight beats
//   io    : operand/result bus (slave side)
// Stage 1 registers the block-0 sum and both carry hypotheses of every
// upper block; stage 2 resolves the select chain and registers the
// result. One beat per cycle when the consumer keeps out_ready high.
module pipelined_select_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input logic                    Clk,
  input logic                    Reset,
  pipelined_select_adder_if.slave io
);

  localparam int unsigned NBLK = nblk(WIDTH, BLOCK);
  localparam int unsigned NUP  = NBLK - 1;

  if ((WIDTH % BLOCK) != 0 || NBLK < 2) begin : g_param_check
    $fatal(1, "pipelined_select_adder: WIDTH must be a multiple of BLOCK with at least two blocks");
  end

  // ---------------- operand conditioning ----------------
  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign op    = op_e'(io.sub);
  assign b_eff = (op == OP_SUB) ? ~io.B : io.B;
  assign c0    = (op == OP_SUB) ? 1'b1 : io.cin;

  // ---------------- stage 1 combinational ----------------
  logic [BLOCK-1:0]           blk0_sum;
  logic                       blk0_carry;
  logic [NUP-1:0][BLOCK-1:0]  hyp_sum0;
  logic [NUP-1:0][BLOCK-1:0]  hyp_sum1;
  logic [NUP-1:0]             hyp_carry0;
  logic [NUP-1:0]             hyp_carry1;
  logic                       msb_ci0;
  logic                       msb_ci1;

  assign {blk0_carry, blk0_sum} = {1'b0, io.A[BLOCK-1:0]} + {1'b0, b_eff[BLOCK-1:0]}
                                + {{BLOCK{1'b0}}, c0};

  for (genvar k = 0; k < NUP; k++) begin : g_blk
    select_block #(.BLOCK(BLOCK)) u_blk (
      .a      (io.A[(k+1)*BLOCK +: BLOCK]),
      .b      (b_eff[(k+1)*BLOCK +: BLOCK]),
      .sum0   (hyp_sum0[k]),
      .sum1   (hyp_sum1[k]),
      .carry0 (hyp_carry0[k]),
      .carry1 (hyp_carry1[k])
    );
  end

  // Carry into the MSB recovered as a ^ b ^ sum at that bit, once per
  // hypothesis of the top block; stage 2 picks the matching one.
  assign msb_ci0 = io.A[WIDTH-1] ^ b_eff[WIDTH-1] ^ hyp_sum0[NUP-1][BLOCK-1];
  assign msb_ci1 = io.A[WIDTH-1] ^ b_eff[WIDTH-1] ^ hyp_sum1[NUP-1][BLOCK-1];

  // ---------------- handshake ----------------
  logic s1_valid;
  logic out_valid_q;
  logic s2_free;
  logic s1_adv;
  logic accept;

  assign s2_free     = !out_valid_q || io.out_ready;
  assign s1_adv      = s1_valid && s2_free;
  assign io.in_ready = !s1_valid || s2_free;
  assign accept      = io.in_valid && io.in_ready;

  // ---------------- stage 1 registers ----------------
  logic [BLOCK-1:0]          s1_blk0_sum;
  logic                      s1_blk0_carry;
  logic [NUP-1:0][BLOCK-1:0] s1_sum0;
  logic [NUP-1:0][BLOCK-1:0] s1_sum1;
  logic [NUP-1:0]            s1_carry0;
  logic [NUP-1:0]            s1_carry1;
  logic                      s1_msb_ci0;
  logic                      s1_msb_ci1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid      <= 1'b0;
      s1_blk0_sum   <= '0;
      s1_blk0_carry <= 1'b0;
      s1_sum0       <= '0;
      s1_sum1       <= '0;
      s1_carry0     <= '0;
      s1_carry1     <= '0;
      s1_msb_ci0    <= 1'b0;
      s1_msb_ci1    <= 1'b0;
    end else if (accept) begin
      s1_valid      <= 1'b1;
      s1_blk0_sum   <= blk0_sum;
      s1_blk0_carry <= blk0_carry;
      s1_sum0       <= hyp_sum0;
      s1_sum1       <= hyp_sum1;
      s1_carry0     <= hyp_carry0;
      s1_carry1     <= hyp_carry1;
      s1_msb_ci0    <= msb_ci0;
      s1_msb_ci1    <= msb_ci1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // ---------------- stage 2 select chain ----------------
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_msb_ci;

  always_comb begin
    logic c;
    c          = s1_blk0_carry;
    res_sum    = '0;
    res_msb_ci = 1'b0;
    res_sum[BLOCK-1:0] = s1_blk0_sum;
    for (int unsigned k = 0; k < NUP; k++) begin
      res_sum[(k+1)*BLOCK +: BLOCK] = c ? s1_sum1[k] : s1_sum0[k];
      if (k == NUP - 1) begin
        res_msb_ci = c ? s1_msb_ci1 : s1_msb_ci0;
      end
      c = c ? s1_carry1[k] : s1_carry0[k];
    end
    res_cout = c;
  end

  // ---------------- stage 2 registers ----------------
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (s1_adv) begin
      out_valid_q <= 1'b1;
      s_q         <= res_sum;
      cout_q      <= res_cout;
      ovf_q       <= res_msb_ci ^ res_cout;
    end else if (io.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.S         = s_q;
  assign io.cout      = cout_q;
  assign io.overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_select_adder.sv
module tb_pipelined_select_adder;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  pipelined_select_adder_if #(.WIDTH(16)) bus0 ();
  pipelined_select_adder_if #(.WIDTH(32)) bus1 ();

  pipelined_select_adder #(.WIDTH(16), .BLOCK(4)) dut0 (
    .Clk   (Clk),
    .Reset (Reset),
    .io    (bus0)
  );

  pipelined_select_adder #(.WIDTH(32), .BLOCK(8)) dut1 (
    .Clk   (Clk),
    .Reset (Reset),
    .io    (bus1)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[14];

  logic [65:0] q0[$];
  logic [65:0] q1[$];
  int acc1 = 0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic beat0(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    bus0.in_valid = 1'b1;
    bus0.A        = a;
    bus0.B        = b;
    bus0.cin      = cin;
    bus0.sub      = sub;
  endtask

  function automatic logic [65:0] out0();
    return {33'd0, bus0.out_valid, bus0.overflow, bus0.cout, 16'd0, bus0.S};
  endfunction

  function automatic logic [65:0] exp_out(input logic v, input logic ov,
                                          input logic co, input logic [31:0] s);
    return {33'd0, v, ov, co, s};
  endfunction

  // Reference: plain wide addition; signed overflow from operand/result signs.
  function automatic logic [65:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin,
                                        input logic sub);
    logic [63:0] mask, be, full;
    logic [31:0] s;
    logic        c0, co, ov;
    mask = (64'd1 << w) - 64'd1;
    be   = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
    c0   = sub ? 1'b1 : cin;
    full = {32'd0, a} + be + {63'd0, c0};
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
    return {32'd0, ov, co, s};
  endfunction

  function automatic logic [31:0] rop(input int w);
    logic [31:0] r;
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(7))
      0:       r = '0;
      1:       r = '1;
      2:       r = 32'd1 << (w - 1);
      3:       r = (32'd1 << (w - 1)) - 32'd1;
      default: r = $urandom;
    endcase
    return r & m;
  endfunction

  // One random-stimulus cycle on both instances; called at edge+1.
  task automatic rand_cycle(input bit gen);
    logic v, rdy;
    logic [65:0] e;
    v   = gen && ($urandom_range(3) != 0);
    rdy = !gen || ($urandom_range(9) < 7);
    bus0.in_valid = v;  bus1.in_valid = v;
    bus0.out_ready = rdy; bus1.out_ready = rdy;
    bus0.A = rop(16); bus0.B = rop(16);
    bus0.cin = 1'($urandom_range(1)); bus0.sub = 1'($urandom_range(1));
    bus1.A = rop(32); bus1.B = rop(32);
    bus1.cin = 1'($urandom_range(1)); bus1.sub = 1'($urandom_range(1));
    #1;
    if (bus0.out_valid && bus0.out_ready) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL rand16_spurious: got S=%0h, expected no result", bus0.S);
      end else begin
        e = q0.pop_front();
        chk("rand16", {32'd0, bus0.overflow, bus0.cout, 16'd0, bus0.S}, e);
      end
    end
    if (bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL rand32_spurious: got S=%0h, expected no result", bus1.S);
      end else begin
        e = q1.pop_front();
        chk("rand32", {32'd0, bus1.overflow, bus1.cout, bus1.S}, e);
      end
    end
    if (bus0.in_valid && bus0.in_ready)
      q0.push_back(model(16, {16'd0, bus0.A}, {16'd0, bus0.B}, bus0.cin, bus0.sub));
    if (bus1.in_valid && bus1.in_ready) begin
      q1.push_back(model(32, bus1.A, bus1.B, bus1.cin, bus1.sub));
      acc1++;
    end
    tick();
  endtask

  initial begin
    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[4]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[7]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[8]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[10] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[11] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[12] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[13] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    Reset = 1'b1;
    bus0.in_valid = 1'b0; bus0.A = '0; bus0.B = '0; bus0.cin = 1'b0; bus0.sub = 1'b0;
    bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.A = '0; bus1.B = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
    bus1.out_ready = 1'b1;

    // Reset state
    #12;
    chk("reset_out16", out0(), '0);
    chk("reset_out32", {33'd0, bus1.out_valid, bus1.overflow, bus1.cout, bus1.S}, '0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("reset_in_ready", {65'd0, bus0.in_ready}, 66'd1);
    tick();

    // Table vectors, one beat at a time, 2-edge latency
    for (int i = 0; i < 14; i++) begin
      beat0(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      #1;
      chk($sformatf("vec%0d_in_ready", i), {65'd0, bus0.in_ready}, 66'd1);
      tick();
      bus0.in_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d", i), out0(),
          exp_out(1'b1, vecs[i].ovf, vecs[i].cout, {16'd0, vecs[i].s}));
    end
    tick();

    // Back-to-back full throughput
    beat0(16'd1, 16'd1, 1'b0, 1'b0); #1;
    chk("b2b_ir0", {65'd0, bus0.in_ready}, 66'd1);
    tick();
    beat0(16'd2, 16'd2, 1'b0, 1'b0); #1;
    chk("b2b_ir1", {65'd0, bus0.in_ready}, 66'd1);
    tick();
    beat0(16'd3, 16'd3, 1'b0, 1'b0); #1;
    chk("b2b_ir2", {65'd0, bus0.in_ready}, 66'd1);
    chk("b2b_s2", out0(), exp_out(1'b1, 1'b0, 1'b0, 32'd2));
    tick();
    bus0.in_valid = 1'b0;
    chk("b2b_s4", out0(), exp_out(1'b1, 1'b0, 1'b0, 32'd4));
    tick();
    chk("b2b_s6", out0(), exp_out(1'b1, 1'b0, 1'b0, 32'd6));
    tick();
    chk("b2b_idle", {65'd0, bus0.out_valid}, 66'd0);

    // Backpressure: two beats in, third offered while stalled
    bus0.out_ready = 1'b0;
    beat0(16'd10, 16'd20, 1'b0, 1'b0); #1;
    chk("bp_ir0", {65'd0, bus0.in_ready}, 66'd1);
    tick();
    beat0(16'd100, 16'd200, 1'b0, 1'b0); #1;
    chk("bp_ir1", {65'd0, bus0.in_ready}, 66'd1);
    tick();
    beat0(16'd1000, 16'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_stall_ir%0d", i), {65'd0, bus0.in_ready}, 66'd0);
      chk($sformatf("bp_stall_hold%0d", i), out0(), exp_out(1'b1, 1'b0, 1'b0, 32'd30));
      tick();
    end
    bus0.out_ready = 1'b1; #1;
    chk("bp_release_ir", {65'd0, bus0.in_ready}, 66'd1);
    tick();
    bus0.in_valid = 1'b0;
    chk("bp_second", out0(), exp_out(1'b1, 1'b0, 1'b0, 32'd300));
    tick();
    chk("bp_third", out0(), exp_out(1'b1, 1'b0, 1'b0, 32'd1001));
    tick();
    chk("bp_empty", {65'd0, bus0.out_valid}, 66'd0);

    // Asynchronous reset with two beats in flight
    beat0(16'h0101, 16'h0202, 1'b0, 1'b0);
    tick();
    beat0(16'h0303, 16'h0404, 1'b0, 1'b0);
    tick();
    bus0.in_valid = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    chk("areset_out", out0(), '0);
    #2;
    Reset = 1'b0;
    beat0(16'd4, 16'd5, 1'b0, 1'b0);
    #1;
    chk("areset_in_ready", {65'd0, bus0.in_ready}, 66'd1);
    tick();
    bus0.in_valid = 1'b0;
    chk("areset_discard", {65'd0, bus0.out_valid}, 66'd0);
    tick();
    chk("areset_first", out0(), exp_out(1'b1, 1'b0, 1'b0, 32'd9));
    tick();
    chk("areset_idle", {65'd0, bus0.out_valid}, 66'd0);

    // 32-bit, 8-bit blocks
    bus1.in_valid = 1'b1; bus1.A = 32'hFFFF_FFFF; bus1.B = 32'd0;
    bus1.cin = 1'b1; bus1.sub = 1'b0;
    tick();
    bus1.A = 32'h7FFF_FFFF; bus1.B = 32'd1; bus1.cin = 1'b0;
    tick();
    bus1.in_valid = 1'b0;
    chk("w32_carry", {33'd0, bus1.out_valid, bus1.overflow, bus1.cout, bus1.S},
        exp_out(1'b1, 1'b0, 1'b1, 32'd0));
    tick();
    chk("w32_ovf", {33'd0, bus1.out_valid, bus1.overflow, bus1.cout, bus1.S},
        exp_out(1'b1, 1'b1, 1'b0, 32'h8000_0000));
    tick();

    // Randomised beats with random backpressure
    for (int c = 0; c < 40000 && acc1 < 10000; c++) rand_cycle(1'b1);
    chk("rand_accepted", {34'd0, 32'(acc1 >= 10000 ? 1 : 0)}, 66'd1);
    for (int c = 0; c < 20 && (q0.size() != 0 || q1.size() != 0); c++) rand_cycle(1'b0);
    chk("drain16", {34'd0, 32'(q0.size())}, 66'd0);
    chk("drain32", {34'd0, 32'(q1.size())}, 66'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
